sys_reset_req_gen: RTL and testbench
====================================

Name: sys_reset_req_gen

Overview:
- Upstream request stage for proc_sys_reset. Merges a software reset request and a watchdog timeout into one active-high reset pulse of fixed width.
- The pulse drives proc_sys_reset aux_reset_in with C_AUX_RESET_HIGH=1.
- The block monitors peripheral_aresetn fed back from proc_sys_reset to confirm that the reset sequence completed.
- It records the reset cause in sticky bits.

Parameters:
C_PULSE_WIDTH, 16, aux_reset_out high time in cycles (>=1)
C_WDT_WIDTH, 16, watchdog counter width
C_ACK_TIMEOUT, 1024, max cycles in WAIT_ACK before giving up (>=1)
C_HOLDOFF, 8, cycles after completion during which new requests are ignored (>=1)

Ports:
slowest_sync_clk  in  1  sole clock
ext_reset_in  in  1  asynchronous, active-high reset
sw_rst_req  in  1  software request; rising edge triggers
wdt_en  in  1  watchdog enable
wdt_kick  in  1  watchdog reload strobe
wdt_load  in  C_WDT_WIDTH  watchdog reload value
peripheral_aresetn  in  1  feedback from proc_sys_reset, synchronous to slowest_sync_clk
cause_clr  in  1  clears rst_cause
aux_reset_out  out  1  active-high reset request pulse
rst_busy  out  1  high whenever state != IDLE
rst_cause  out  3  sticky: [0] sw, [1] wdt, [2] ack timeout
wdt_count  out  C_WDT_WIDTH  current watchdog count

Behaviour:
- Reset (ext_reset_in=1, async) forces:
  - state=IDLE, aux_reset_out=0, rst_busy=0, rst_cause=0, wdt_count=0
  - sw_rst_req edge register = 1, so a request held high through reset does not trigger.
- All outputs are registered.
- sw edge = sw_rst_req & ~sw_rst_req_q.
- Watchdog, evaluated in IDLE only:
  - wdt_en=0: wdt_count <= wdt_load.
  - wdt_en=1 and wdt_kick=1: wdt_count <= wdt_load.
  - wdt_en=1, no kick, count != 0: decrement.
  - wdt_en=1, no kick, count == 0: wdt trigger.
  - Outside IDLE the counter is frozen. On entry to IDLE it reloads wdt_load.
- FSM states: IDLE, ASSERT, WAIT_ACK, HOLDOFF.
- IDLE:
  - On sw edge or wdt trigger: go to ASSERT, set the matching rst_cause bit(s). Simultaneous triggers set both bits.
  - aux_reset_out rises on the clock edge after the trigger cycle (latency 1).
- ASSERT:
  - aux_reset_out=1 for exactly C_PULSE_WIDTH cycles, then go to WAIT_ACK with aux_reset_out=0.
  - seen_low flag is cleared on ASSERT entry and set on any cycle in ASSERT/WAIT_ACK with peripheral_aresetn=0.
- WAIT_ACK:
  - Exit to HOLDOFF when seen_low=1 and peripheral_aresetn=1.
  - A timeout counter starts at 0 on entry. If C_ACK_TIMEOUT cycles elapse without the exit condition, set rst_cause[2] and go to HOLDOFF.
- HOLDOFF: wait C_HOLDOFF cycles, then go to IDLE.
- Requests outside IDLE:
  - sw edges are dropped.
  - A level still high on return to IDLE does not retrigger; a new rising edge is required.
- cause_clr clears all rst_cause bits. If a set occurs in the same cycle, the set wins for that bit.
- rst_busy = (state != IDLE), registered together with the state.
- Reset mid-operation: immediate return to the reset values above. No pulse completion is guaranteed.
- Counters wrap-free:
  - Pulse, timeout and holdoff counters are sized with clog2(param+1).
  - wdt_count saturates at 0 and never underflows.

Test Plan:
1. Reset release, then sw_rst_req 0->1 at cycle 10:
   - aux_reset_out=1 for cycles 11-26 (16 cycles), rst_cause=3'b001.
   - Model drops peripheral_aresetn at 30 and raises it at 60 -> HOLDOFF 61-68, IDLE at 69.
2. wdt_en=1, wdt_load=5, no kicks:
   - wdt_count 5,4,3,2,1,0; trigger on the count==0 cycle.
   - aux_reset_out asserts the next cycle, rst_cause=3'b010.
   - Kicking every 4 cycles instead never triggers.
3. peripheral_aresetn held at 1 after the pulse:
   - After 1024 cycles in WAIT_ACK, rst_cause[2]=1 and the FSM goes to HOLDOFF.
4. sw edge and wdt trigger in the same IDLE cycle:
   - One pulse only, rst_cause=3'b011.
   - A second sw edge during ASSERT is ignored.
5. ext_reset_in pulsed during ASSERT cycle 5:
   - aux_reset_out=0 and rst_busy=0 immediately (async), rst_cause=0, state IDLE.
6. cause_clr asserted in the same cycle as a new sw trigger:
   - rst_cause[0]=1 afterward.
   - cause_clr alone -> rst_cause=0.

Source files
------------

// File: rtl/sys_reset_req_gen_if.sv
// Request/status bundle between the reset-request generator and its environment.
// Latency: none, plain nets grouped for port hygiene.
// Backpressure: none; every member is a level or a single-cycle strobe.
interface sys_reset_req_gen_if #(
  parameter int C_WDT_WIDTH = 16
) ();

  // Requests and controls into the generator
  logic                   sw_rst_req;
  logic                   wdt_en;
  logic                   wdt_kick;
  logic [C_WDT_WIDTH-1:0] wdt_load;
  logic                   peripheral_aresetn;
  logic                   cause_clr;

  // Status and pulse out of the generator
  logic                   aux_reset_out;
  logic                   rst_busy;
  logic [2:0]             rst_cause;
  logic [C_WDT_WIDTH-1:0] wdt_count;

  // Environment side: software, watchdog controller and proc_sys_reset feedback
  modport master (
    output sw_rst_req, wdt_en, wdt_kick, wdt_load, peripheral_aresetn, cause_clr,
    input  aux_reset_out, rst_busy, rst_cause, wdt_count
  );

  // Generator side
  modport slave (
    input  sw_rst_req, wdt_en, wdt_kick, wdt_load, peripheral_aresetn, cause_clr,
    output aux_reset_out, rst_busy, rst_cause, wdt_count
  );

endinterface

// File: rtl/sys_reset_req_gen.sv
// Merges a sw reset request and a watchdog expiry into one fixed-width aux reset pulse.
// Latency: aux_reset_out rises one cycle after the trigger cycle; all outputs registered.
// Backpressure: none; requests outside IDLE are dropped and a fresh sw rising edge is required.
module sys_reset_req_gen #(
  parameter int C_PULSE_WIDTH = 16,
  parameter int C_WDT_WIDTH   = 16,
  parameter int C_ACK_TIMEOUT = 1024,
  parameter int C_HOLDOFF     = 8
) (
  input  logic               slowest_sync_clk,
  input  logic               ext_reset_in,
  sys_reset_req_gen_if.slave bus
);

  // Counters are sized to hold their terminal value without wrapping
  localparam int PW_W = $clog2(C_PULSE_WIDTH + 1);
  localparam int TO_W = $clog2(C_ACK_TIMEOUT + 1);
  localparam int HO_W = $clog2(C_HOLDOFF + 1);

  // Last count value of each timed phase (phases count 0 .. N-1)
  localparam logic [PW_W-1:0] PULSE_LAST = PW_W'(C_PULSE_WIDTH - 1);
  localparam logic [TO_W-1:0] ACK_LAST   = TO_W'(C_ACK_TIMEOUT - 1);
  localparam logic [HO_W-1:0] HOLD_LAST  = HO_W'(C_HOLDOFF - 1);

  localparam logic [PW_W-1:0]        PW_ONE  = PW_W'(1);
  localparam logic [TO_W-1:0]        TO_ONE  = TO_W'(1);
  localparam logic [HO_W-1:0]        HO_ONE  = HO_W'(1);
  localparam logic [C_WDT_WIDTH-1:0] WDT_ONE = C_WDT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sw_rst_req_q, sw_rst_req_d;
  logic                   aux_reset_out_q, aux_reset_out_d;
  logic                   rst_busy_q, rst_busy_d;
  logic [2:0]             rst_cause_q, rst_cause_d;
  logic [C_WDT_WIDTH-1:0] wdt_count_q, wdt_count_d;
  logic [PW_W-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [TO_W-1:0]        ack_cnt_q, ack_cnt_d;
  logic [HO_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic                   seen_low_q, seen_low_d;

  logic                   in_idle;
  logic                   sw_edge;
  logic                   wdt_trig;
  logic                   trigger;
  logic                   ack_done;
  logic [2:0]             cause_set;

  // Request detection: sw rising edge and watchdog expiry; only acted on in IDLE
  always_comb begin
    in_idle      = (state_q == ST_IDLE);
    sw_rst_req_d = bus.sw_rst_req;
    sw_edge      = bus.sw_rst_req & ~sw_rst_req_q;
    wdt_trig     = in_idle & bus.wdt_en & ~bus.wdt_kick & (wdt_count_q == '0);
    trigger      = in_idle & (sw_edge | wdt_trig);
    // Completion needs a low phase of peripheral_aresetn followed by its release
    ack_done     = seen_low_q & bus.peripheral_aresetn;
  end

  // Watchdog: runs in IDLE, frozen elsewhere, reloaded on the way back into IDLE
  always_comb begin
    wdt_count_d = wdt_count_q;
    if (in_idle) begin
      if (!bus.wdt_en || bus.wdt_kick) begin
        wdt_count_d = bus.wdt_load;
      end else if (wdt_count_q != '0) begin
        wdt_count_d = wdt_count_q - WDT_ONE;
      end
      // count == 0 holds at zero; the expiry itself is wdt_trig
    end else if (state_d == ST_IDLE) begin
      wdt_count_d = bus.wdt_load;
    end
  end

  // Sequencer: IDLE -> ASSERT (pulse) -> WAIT_ACK (feedback or timeout) -> HOLDOFF -> IDLE
  always_comb begin
    state_d         = state_q;
    pulse_cnt_d     = pulse_cnt_q;
    ack_cnt_d       = ack_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    seen_low_d      = seen_low_q;
    aux_reset_out_d = 1'b0;
    cause_set       = 3'b000;

    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d         = ST_ASSERT;
          aux_reset_out_d = 1'b1;
          pulse_cnt_d     = '0;
          seen_low_d      = 1'b0;
          cause_set       = {1'b0, wdt_trig, sw_edge};
        end
      end

      ST_ASSERT: begin
        if (!bus.peripheral_aresetn) begin
          seen_low_d = 1'b1;
        end
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d   = ST_WAIT_ACK;
          ack_cnt_d = '0;
        end else begin
          pulse_cnt_d     = pulse_cnt_q + PW_ONE;
          aux_reset_out_d = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (!bus.peripheral_aresetn) begin
          seen_low_d = 1'b1;
        end
        if (ack_done) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = '0;
        end else if (ack_cnt_q == ACK_LAST) begin
          // proc_sys_reset never confirmed; give up and record it
          state_d      = ST_HOLDOFF;
          hold_cnt_d   = '0;
          cause_set[2] = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + TO_ONE;
        end
      end

      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HO_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky cause bits: a set in the same cycle as a clear wins for that bit
  always_comb begin
    rst_cause_d = (rst_cause_q & ~{3{bus.cause_clr}}) | cause_set;
    rst_busy_d  = (state_d != ST_IDLE);
  end

  // All state and outputs; sw edge register resets high so a held request cannot fire
  always_ff @(posedge slowest_sync_clk or posedge ext_reset_in) begin
    if (ext_reset_in) begin
      state_q         <= ST_IDLE;
      sw_rst_req_q    <= 1'b1;
      aux_reset_out_q <= 1'b0;
      rst_busy_q      <= 1'b0;
      rst_cause_q     <= 3'b000;
      wdt_count_q     <= '0;
      pulse_cnt_q     <= '0;
      ack_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      seen_low_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sw_rst_req_q    <= sw_rst_req_d;
      aux_reset_out_q <= aux_reset_out_d;
      rst_busy_q      <= rst_busy_d;
      rst_cause_q     <= rst_cause_d;
      wdt_count_q     <= wdt_count_d;
      pulse_cnt_q     <= pulse_cnt_d;
      ack_cnt_q       <= ack_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      seen_low_q      <= seen_low_d;
    end
  end

  assign bus.aux_reset_out = aux_reset_out_q;
  assign bus.rst_busy      = rst_busy_q;
  assign bus.rst_cause     = rst_cause_q;
  assign bus.wdt_count     = wdt_count_q;

endmodule

// File: tb/tb_sys_reset_req_gen.sv
// Directed bench for sys_reset_req_gen with a pulse scoreboard fed at stimulus time.
// Latency: expected pulse start is the cycle after the trigger cycle.
// Backpressure: none; peripheral_aresetn is modelled by the directed steps.
`timescale 1ns/1ps
module tb_sys_reset_req_gen;

  localparam int PW = 16;
  localparam int WW = 16;
  localparam int TO = 1024;
  localparam int HO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    int         start;
    int         width;
    logic [2:0] cause;
  } pulse_t;

  pulse_t     sb[$];
  pulse_t     pe;
  logic       aux_prev = 1'b0;
  int         rise_cyc = 0;
  logic [2:0] rise_cause = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_reset_req_gen_if #(.C_WDT_WIDTH(WW)) bus ();

  sys_reset_req_gen #(
    .C_PULSE_WIDTH (PW),
    .C_WDT_WIDTH   (WW),
    .C_ACK_TIMEOUT (TO),
    .C_HOLDOFF     (HO)
  ) dut (
    .slowest_sync_clk (clk),
    .ext_reset_in     (rst),
    .bus              (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic expect_pulse(input int start, input int width, input logic [2:0] cause);
    pulse_t e;
    e.start = start;
    e.width = width;
    e.cause = cause;
    sb.push_back(e);
  endtask

  // Wait for the pulse to end, model a short proc_sys_reset sequence, wait for IDLE
  task automatic ack_and_idle();
    int n;
    n = 0;
    while (bus.aux_reset_out !== 1'b0 && n < 64) begin step(1); n++; end
    chk("pulse_ends", 32'(bus.aux_reset_out), 32'(1'b0));
    bus.peripheral_aresetn = 1'b0;
    step(3);
    bus.peripheral_aresetn = 1'b1;
    n = 0;
    while (bus.rst_busy !== 1'b0 && n < 64) begin step(1); n++; end
    chk("back_to_idle", 32'(bus.rst_busy), 32'(1'b0));
  endtask

  // Pulse monitor: measures every aux_reset_out pulse and pops its expectation
  always @(negedge clk) begin
    if (bus.aux_reset_out === 1'b1 && aux_prev !== 1'b1) begin
      rise_cyc   = cyc;
      rise_cause = bus.rst_cause;
    end else if (bus.aux_reset_out !== 1'b1 && aux_prev === 1'b1) begin
      chk("pulse_expected", 32'(sb.size() != 0), 32'(1'b1));
      if (sb.size() != 0) begin
        pe = sb.pop_front();
        chk("pulse_start", rise_cyc, pe.start);
        chk("pulse_width", cyc - rise_cyc, pe.width);
        chk("pulse_cause", 32'(rise_cause), 32'(pe.cause));
      end
    end
    aux_prev = bus.aux_reset_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, required finish before 1000000ns");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    int c;
    int s;
    logic busy_seen;

    // Reset with a sw request held high throughout
    bus.sw_rst_req         = 1'b1;
    bus.wdt_en             = 1'b0;
    bus.wdt_kick           = 1'b0;
    bus.wdt_load           = WW'(5);
    bus.peripheral_aresetn = 1'b1;
    bus.cause_clr          = 1'b0;
    step(3);
    chk("rst_aux", 32'(bus.aux_reset_out), 32'(1'b0));
    chk("rst_busy", 32'(bus.rst_busy), 32'(1'b0));
    chk("rst_cause", 32'(bus.rst_cause), 32'(3'b000));
    chk("rst_wdt", 32'(bus.wdt_count), 32'(0));
    rst  = 1'b0;
    base = cyc;
    step(3);
    chk("held_req_no_trig", 32'(bus.rst_busy), 32'(1'b0));
    bus.sw_rst_req = 1'b0;

    // T1: sw edge at cycle 10, feedback low 30..59, high from 60
    goto(base + 10);
    bus.sw_rst_req = 1'b1;
    expect_pulse(base + 11, PW, 3'b001);
    goto(base + 11);
    chk("t1_aux_rise", 32'(bus.aux_reset_out), 32'(1'b1));
    chk("t1_busy", 32'(bus.rst_busy), 32'(1'b1));
    chk("t1_cause", 32'(bus.rst_cause), 32'(3'b001));
    goto(base + 26);
    chk("t1_aux_last", 32'(bus.aux_reset_out), 32'(1'b1));
    goto(base + 27);
    chk("t1_aux_fall", 32'(bus.aux_reset_out), 32'(1'b0));
    goto(base + 30);
    bus.peripheral_aresetn = 1'b0;
    goto(base + 60);
    bus.peripheral_aresetn = 1'b1;
    chk("t1_wait_busy", 32'(bus.rst_busy), 32'(1'b1));
    goto(base + 68);
    chk("t1_holdoff_busy", 32'(bus.rst_busy), 32'(1'b1));
    goto(base + 69);
    chk("t1_idle", 32'(bus.rst_busy), 32'(1'b0));
    goto(base + 75);
    chk("t1_level_no_retrig", 32'(bus.rst_busy), 32'(1'b0));
    bus.sw_rst_req = 1'b0;

    // cause_clr alone
    bus.cause_clr = 1'b1;
    step(1);
    bus.cause_clr = 1'b0;
    chk("clr_alone", 32'(bus.rst_cause), 32'(3'b000));

    // T2: watchdog countdown 5..0 without kicks
    chk("wdt_loaded", 32'(bus.wdt_count), 32'(5));
    bus.wdt_en = 1'b1;
    c = cyc;
    expect_pulse(c + 6, PW, 3'b010);
    for (int i = 0; i <= 5; i++) begin
      chk("wdt_down", 32'(bus.wdt_count), 32'(5 - i));
      if (i < 5) step(1);
    end
    step(1);
    bus.wdt_en = 1'b0;
    chk("t2_aux_rise", 32'(bus.aux_reset_out), 32'(1'b1));
    chk("t2_cause", 32'(bus.rst_cause), 32'(3'b010));
    step(3);
    chk("wdt_frozen", 32'(bus.wdt_count), 32'(0));
    ack_and_idle();
    chk("wdt_reload_on_idle", 32'(bus.wdt_count), 32'(5));

    // T2b: kick every 4 cycles, must never expire
    busy_seen = 1'b0;
    bus.wdt_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.wdt_kick = ((i % 4) == 3);
      chk("wdt_kick_cnt", 32'(bus.wdt_count), 32'(5 - (i % 4)));
      busy_seen = busy_seen | bus.rst_busy;
      step(1);
    end
    bus.wdt_en   = 1'b0;
    bus.wdt_kick = 1'b0;
    chk("kick_no_trigger", 32'(busy_seen), 32'(1'b0));

    // T3: feedback never toggles, ack timeout
    bus.sw_rst_req = 1'b1;
    s = cyc + 1;
    expect_pulse(s, PW, 3'b011);
    step(1);
    bus.sw_rst_req = 1'b0;
    goto(s + PW + TO - 1);
    chk("t3_pre_timeout_cause", 32'(bus.rst_cause), 32'(3'b011));
    chk("t3_pre_timeout_busy", 32'(bus.rst_busy), 32'(1'b1));
    goto(s + PW + TO);
    chk("t3_timeout_cause", 32'(bus.rst_cause), 32'(3'b111));
    goto(s + PW + TO + HO - 1);
    chk("t3_holdoff_busy", 32'(bus.rst_busy), 32'(1'b1));
    goto(s + PW + TO + HO);
    chk("t3_idle", 32'(bus.rst_busy), 32'(1'b0));

    // T5: async reset in the 5th ASSERT cycle
    bus.cause_clr = 1'b1;
    step(1);
    bus.cause_clr = 1'b0;
    chk("t5_clr", 32'(bus.rst_cause), 32'(3'b000));
    bus.sw_rst_req = 1'b1;
    s = cyc + 1;
    expect_pulse(s, 4, 3'b001);
    goto(s + 3);
    chk("t5_aux_high", 32'(bus.aux_reset_out), 32'(1'b1));
    goto(s + 4);
    rst = 1'b1;
    #1;
    chk("t5_aux_async", 32'(bus.aux_reset_out), 32'(1'b0));
    chk("t5_busy_async", 32'(bus.rst_busy), 32'(1'b0));
    chk("t5_cause_async", 32'(bus.rst_cause), 32'(3'b000));
    chk("t5_wdt_async", 32'(bus.wdt_count), 32'(0));
    step(2);
    rst = 1'b0;
    step(3);
    chk("t5_held_no_trig", 32'(bus.rst_busy), 32'(1'b0));
    bus.sw_rst_req = 1'b0;
    step(1);

    // T4: sw edge and wdt expiry in the same cycle, extra sw edge during ASSERT
    bus.wdt_load = WW'(3);
    step(1);
    chk("t4_wdt_loaded", 32'(bus.wdt_count), 32'(3));
    bus.wdt_en = 1'b1;
    c = cyc;
    goto(c + 3);
    chk("t4_wdt_zero", 32'(bus.wdt_count), 32'(0));
    bus.sw_rst_req = 1'b1;
    expect_pulse(c + 4, PW, 3'b011);
    step(1);
    bus.wdt_en = 1'b0;
    chk("t4_aux_rise", 32'(bus.aux_reset_out), 32'(1'b1));
    chk("t4_cause", 32'(bus.rst_cause), 32'(3'b011));
    step(1);
    bus.sw_rst_req = 1'b0;
    step(2);
    bus.sw_rst_req = 1'b1;
    step(1);
    ack_and_idle();
    step(5);
    chk("t4_no_second_pulse", 32'(bus.rst_busy), 32'(1'b0));
    bus.sw_rst_req = 1'b0;
    step(1);

    // T6: cause_clr together with a new sw trigger, then clear alone
    bus.sw_rst_req = 1'b1;
    bus.cause_clr  = 1'b1;
    expect_pulse(cyc + 1, PW, 3'b001);
    step(1);
    bus.cause_clr  = 1'b0;
    bus.sw_rst_req = 1'b0;
    chk("t6_set_wins", 32'(bus.rst_cause), 32'(3'b001));
    ack_and_idle();
    bus.cause_clr = 1'b1;
    step(1);
    bus.cause_clr = 1'b0;
    chk("t6_clr_alone", 32'(bus.rst_cause), 32'(3'b000));

    step(2);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
